// File: rtl/riscv_defines.sv
// riscv_defines
//   Shared ALU definitions for the issue stage: opcode width, opcodes, vector
//   modes, the issue request record, and the issue FSM state encoding.
//   No ports.
package riscv_defines;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 7'b0100111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 7'b0000010;

  localparam logic [1:0] VEC_MODE32 = 2'b00;
  localparam logic [1:0] VEC_MODE16 = 2'b10;
  localparam logic [1:0] VEC_MODE8  = 2'b11;

  // Operation held in the issue request register while it drives the ALU.
  // The destination tag is kept beside it because its width is a parameter.
  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] op;
    logic [31:0]             operand_a;
    logic [31:0]             operand_b;
    logic [31:0]             operand_c;
    logic [1:0]              vector_mode;
  } alu_req_t;

  localparam alu_req_t ALU_REQ_RESET = '{
    op:          ALU_ADD,
    operand_a:   32'h0,
    operand_b:   32'h0,
    operand_c:   32'h0,
    vector_mode: 2'b00
  };

  typedef enum logic {
    ISSUE_IDLE = 1'b0,
    ISSUE_BUSY = 1'b1
  } issue_state_e;

endpackage

// File: rtl/riscv_alu_issue_if.sv
// riscv_alu_issue_if
//   Request handshake from decode into the ALU issue stage.
//   master: decode side (drives valid + payload, receives ready)
//   slave : issue side  (receives valid + payload, drives ready)
interface riscv_alu_issue_if #(
  parameter int RD_ADDR_WIDTH = 6
) ();
  import riscv_defines::*;

  logic                     id_valid_i;
  logic                     id_ready_o;
  logic [ALU_OP_WIDTH-1:0]  id_operator_i;
  logic [31:0]              id_operand_a_i;
  logic [31:0]              id_operand_b_i;
  logic [31:0]              id_operand_c_i;
  logic [1:0]               id_vector_mode_i;
  logic [RD_ADDR_WIDTH-1:0] id_rd_addr_i;

  modport master (
    output id_valid_i, id_operator_i, id_operand_a_i, id_operand_b_i,
           id_operand_c_i, id_vector_mode_i, id_rd_addr_i,
    input  id_ready_o
  );

  modport slave (
    input  id_valid_i, id_operator_i, id_operand_a_i, id_operand_b_i,
           id_operand_c_i, id_vector_mode_i, id_rd_addr_i,
    output id_ready_o
  );

endinterface

// File: rtl/riscv_alu_result_fifo.sv
// riscv_alu_result_fifo
//   Result FIFO between ALU completion and writeback.
//   clk, rst_n : clock, async active-low reset
//   flush      : empty the FIFO at the next edge (wins over push/pop)
//   push       : write push_data (never asserted when full)
//   pop        : advance the head (never asserted when empty)
//   head       : oldest entry
//   count      : number of valid entries
module riscv_alu_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 39
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/riscv_alu_issue.sv
// riscv_alu_issue
//   Issue stage for a single ALU: registers one op from decode, drives the
//   ALU until it reports a result, and queues results for writeback.
//   Optional feature macro: RISCV_ALU_ISSUE_PERF_EN (performance counters).
//   clk, rst_n        : clock, async active-low reset
//   flush_i           : drop the in-flight op and all queued results
//   id                : decode request handshake (slave modport)
//   alu_*_o           : registered ALU drive
//   alu_ready_i, alu_result_i, alu_comparison_result_i : ALU outputs
//   alu_ex_ready_o    : result FIFO has room
//   wb_*              : writeback handshake and FIFO head
//   perf_issued_o, perf_stall_o : completed ops / busy-stall cycles
//
//   state | meaning
//   IDLE  | request register empty, ALU drive holds last values
//   BUSY  | request register holds a valid op driving the ALU
module riscv_alu_issue
  import riscv_defines::*;
#(
  parameter int RD_ADDR_WIDTH = 6,
  parameter int RESULT_DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  riscv_alu_issue_if.slave         id,
  output logic [ALU_OP_WIDTH-1:0]  alu_operator_o,
  output logic [31:0]              alu_operand_a_o,
  output logic [31:0]              alu_operand_b_o,
  output logic [31:0]              alu_operand_c_o,
  output logic [1:0]               alu_vector_mode_o,
  input  logic                     alu_ready_i,
  input  logic [31:0]              alu_result_i,
  input  logic                     alu_comparison_result_i,
  output logic                     alu_ex_ready_o,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [31:0]              wb_result_o,
  output logic                     wb_cmp_o,
  output logic [RD_ADDR_WIDTH-1:0] wb_rd_addr_o,
  output logic [31:0]              perf_issued_o,
  output logic [31:0]              perf_stall_o
);

  localparam int CNT_W  = $clog2(RESULT_DEPTH) + 1;
  localparam int DATA_W = 32 + 1 + RD_ADDR_WIDTH;

  issue_state_e             state_q, state_d;
  alu_req_t                 req_q;
  logic [RD_ADDR_WIDTH-1:0] tag_q;
  logic                     busy, complete, id_ready, transfer;
  logic                     fifo_push, fifo_pop;
  logic [CNT_W-1:0]         fifo_count;
  logic [DATA_W-1:0]        fifo_head;

  // alu_ex_ready_o depends only on the registered FIFO count, so wb_ready_i
  // never reaches the ALU side combinationally.
  assign alu_ex_ready_o = (fifo_count < CNT_W'(RESULT_DEPTH));

  always_comb begin
    state_d  = state_q;
    busy     = (state_q == ISSUE_BUSY);
    complete = busy & alu_ready_i & alu_ex_ready_o;
    id_ready = ~busy | complete;
    transfer = id.id_valid_i & id_ready & ~flush_i;
    if (flush_i)       state_d = ISSUE_IDLE;
    else if (transfer) state_d = ISSUE_BUSY;
    else if (complete) state_d = ISSUE_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ISSUE_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= ALU_REQ_RESET;
      tag_q <= '0;
    end else if (transfer) begin
      req_q <= '{op:          id.id_operator_i,
                 operand_a:   id.id_operand_a_i,
                 operand_b:   id.id_operand_b_i,
                 operand_c:   id.id_operand_c_i,
                 vector_mode: id.id_vector_mode_i};
      tag_q <= id.id_rd_addr_i;
    end
  end

  assign id.id_ready_o      = id_ready;
  assign alu_operator_o     = req_q.op;
  assign alu_operand_a_o    = req_q.operand_a;
  assign alu_operand_b_o    = req_q.operand_b;
  assign alu_operand_c_o    = req_q.operand_c;
  assign alu_vector_mode_o  = req_q.vector_mode;

  assign fifo_push = complete & ~flush_i;
  assign fifo_pop  = wb_valid_o & wb_ready_i;

  riscv_alu_result_fifo #(
    .DEPTH  (RESULT_DEPTH),
    .DATA_W (DATA_W)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .push      (fifo_push),
    .push_data ({alu_result_i, alu_comparison_result_i, tag_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign wb_valid_o = (fifo_count != '0);
  assign {wb_result_o, wb_cmp_o, wb_rd_addr_o} = fifo_head;

`ifdef RISCV_ALU_ISSUE_PERF_EN
  logic [31:0] issued_q, stall_q;

  // Counters survive flush_i; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (complete)         issued_q <= issued_q + 32'd1;
      if (busy & ~complete) stall_q  <= stall_q + 32'd1;
    end
  end

  assign perf_issued_o = issued_q;
  assign perf_stall_o  = stall_q;
`else
  assign perf_issued_o = 32'h0;
  assign perf_stall_o  = 32'h0;
`endif

endmodule

// File: doc/riscv_alu_issue.md
RISCV_ALU_ISSUE -- requirements
Module: riscv_alu_issue

Interface
REQ-001 Parameter RD_ADDR_WIDTH, default 6, SHALL set destination-tag width.
REQ-002 Parameter RESULT_DEPTH, default 2, SHALL set the result FIFO depth; legal value 2 only.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush_i  in  1  kill in-flight op and empty the result FIFO.
REQ-006 id_valid_i / id_ready_o  in/out  1/1  request handshake from decode.
REQ-007 id_operator_i  in  ALU_OP_WIDTH  ALU opcode.
REQ-008 id_operand_a_i, id_operand_b_i, id_operand_c_i  in  32 each  operands.
REQ-009 id_vector_mode_i  in  2  VEC_MODE8/VEC_MODE16/32-bit.
REQ-010 id_rd_addr_i  in  RD_ADDR_WIDTH  destination tag.
REQ-011 alu_operator_o, alu_operand_{a,b,c}_o, alu_vector_mode_o  out  as above  registered ALU drive.
REQ-012 alu_ready_i  in  1  ALU result valid this cycle.
REQ-013 alu_result_i  in  32; alu_comparison_result_i  in  1  ALU outputs.
REQ-014 alu_ex_ready_o  out  1  downstream able to take the ALU result.
REQ-015 wb_valid_o / wb_ready_i  out/in  1/1  writeback handshake.
REQ-016 wb_result_o  out  32; wb_cmp_o  out  1; wb_rd_addr_o  out  RD_ADDR_WIDTH  FIFO head.
REQ-017 perf_issued_o, perf_stall_o  out  32 each  performance counters.

Function
REQ-018 FSM SHALL have two states, IDLE and BUSY; BUSY means the request register holds a valid op driving the ALU.
REQ-019 Transfer SHALL occur on id_valid_i & id_ready_o; an accepted op loads the request register at that edge.
REQ-020 complete SHALL equal BUSY & alu_ready_i & alu_ex_ready_o.
REQ-021 id_ready_o SHALL equal IDLE | complete, with no dependence on id_valid_i.
REQ-022 Transitions: IDLE->BUSY on transfer; BUSY->IDLE on complete without transfer; BUSY->BUSY on complete with transfer (back-to-back, 1 op/cycle).
REQ-023 alu_ex_ready_o SHALL equal (fifo_count < 2), with no combinational path from wb_ready_i.
REQ-024 On complete, {alu_result_i, alu_comparison_result_i, tag} SHALL be pushed into the FIFO.
REQ-025 Minimum latency SHALL be 2 cycles: transfer at edge N, ALU driven in cycle N+1, wb_valid_o high in cycle N+2.
REQ-026 wb_valid_o SHALL equal (fifo_count != 0); a pop occurs on wb_valid_o & wb_ready_i.
REQ-027 Simultaneous push and pop SHALL leave fifo_count unchanged; a push at count 2 is impossible by REQ-023.
REQ-028 In IDLE, ALU drive outputs SHALL hold their last values; ALU_OP drive SHALL be ALU_ADD after reset.
REQ-029 flush_i SHALL, at the next edge, force IDLE, empty the FIFO and block any transfer in that cycle; it has priority over all other events.
REQ-030 A held op with alu_ready_i low SHALL keep all ALU drive outputs stable.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE, fifo_count 0, pointers 0, request register 0, alu_operator_o ALU_ADD, perf counters 0.
REQ-032 Reset mid-operation SHALL discard the in-flight op and FIFO contents; no writeback occurs for them.
REQ-033 Outputs after reset: id_ready_o 1, wb_valid_o 0, alu_ex_ready_o 1.

Configuration
REQ-034 With RISCV_ALU_ISSUE_PERF_EN defined, perf_issued_o SHALL count completes and perf_stall_o SHALL count cycles with BUSY & ~complete; both wrap at 2^32 and are not cleared by flush_i.
REQ-035 Without RISCV_ALU_ISSUE_PERF_EN, both perf outputs SHALL be constant 0 with no counter flops.

Structure
REQ-036 ALU_OP_WIDTH, opcodes and VEC_MODE* SHALL come from riscv_defines; the request-struct typedef SHALL be added there.
REQ-037 The result FIFO SHALL be a sub-module riscv_alu_result_fifo; the FSM and counters stay in the top.

Verification
REQ-038 ALU_ADD a=5 b=7, wb_ready_i=1 -> wb_valid_o in cycle N+2 with wb_result_o=12 and the sent tag.
REQ-039 Four back-to-back ALU_SUB ops, wb_ready_i=0 -> three accepted, fourth sees id_ready_o=0; release -> results drain in order.
REQ-040 alu_ready_i low for 3 cycles on ALU_SLL a=1 b=4 -> drive stable, perf_stall_o +3, then wb_result_o=16.
REQ-041 flush_i with FIFO full and BUSY -> next cycle wb_valid_o=0, id_ready_o=1, no stale writeback.
REQ-042 rst_n asserted mid-BUSY -> outputs immediately at the REQ-031 and REQ-033 values without a clock edge.
REQ-043 ALU_SLTS a=-1 b=0 with macro defined -> wb_result_o=1, wb_cmp_o=1, perf_issued_o=1; macro undefined -> perf outputs 0.
